// File: rtl/collision_scheduler.sv
// Per-pixel collision detector for configured object pairs with frame snapshot and valid/ack event reporter.
// Optional per-pair saturating hit counters are enabled by defining COLLISION_HIT_COUNT_EN.
module collision_scheduler #(
    parameter int NUM_OBJ   = 6,
    parameter int NUM_PAIRS = 4,
    parameter int IDXW      = 3,
    parameter logic [2*IDXW*NUM_PAIRS-1:0] PAIR_MAP =
        {3'd0, 3'd1, 3'd0, 3'd2, 3'd3, 3'd2, 3'd4, 3'd5},
    localparam int IDW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               pixel_valid,
    input  logic [NUM_OBJ-1:0] drawReq,
    input  logic               startOfFrame,
    output logic               event_valid,
    output logic [IDW-1:0]     event_id,
    input  logic               event_ack,
`ifdef COLLISION_HIT_COUNT_EN
    output logic [15:0]        hit_count,
`endif
    output logic               overrun
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_REPORT = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [NUM_PAIRS-1:0] hit_s, acked_s, remain_s;
    logic [NUM_PAIRS-1:0] sticky_q, sticky_d, snap_q, snap_d;
    logic                 overrun_q, overrun_d, frame_s;
    logic                 event_valid_q, event_valid_d;
    logic [IDW-1:0]       event_id_q, event_id_d;

    function automatic logic [IDW-1:0] lowest_idx(input logic [NUM_PAIRS-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_PAIRS - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_idx = i[IDW-1:0];
            end else begin
                lowest_idx = lowest_idx;
            end
        end
    endfunction

    function automatic logic [NUM_PAIRS-1:0] onehot(input logic [IDW-1:0] idx);
        onehot = {{(NUM_PAIRS-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Pair p is {objA, objB} in PAIR_MAP[2*IDXW*p +: 2*IDXW]; equal indices mean "object drawn".
    for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_hit
        assign hit_s[p] = pixel_valid & enable
                        & drawReq[PAIR_MAP[2*IDXW*p+IDXW +: IDXW]]
                        & drawReq[PAIR_MAP[2*IDXW*p +: IDXW]];
    end

    // Sticky accumulation, snapshot merge and overrun detection.
    always_comb begin
        frame_s = startOfFrame & enable;
        if ((state_q == ST_REPORT) && event_ack) begin
            acked_s = onehot(event_id_q);
        end else begin
            acked_s = '0;
        end
        remain_s = snap_q & ~acked_s;
        if (frame_s) begin
            snap_d    = remain_s | sticky_q | hit_s;
            sticky_d  = '0;
            overrun_d = overrun_q | (|remain_s);
        end else begin
            snap_d    = remain_s;
            sticky_d  = sticky_q | hit_s;
            overrun_d = overrun_q;
        end
    end

    // Reporter next state: stay in REPORT while any snapshot bit is pending.
    always_comb begin
        case (state_q)
            ST_IDLE:   state_d = (|snap_d) ? ST_REPORT : ST_IDLE;
            ST_REPORT: state_d = (|snap_d) ? ST_REPORT : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Reporter outputs, computed for the coming cycle and registered.
    always_comb begin
        if (state_d == ST_REPORT) begin
            event_valid_d = 1'b1;
            event_id_d    = lowest_idx(snap_d);
        end else begin
            event_valid_d = 1'b0;
            event_id_d    = '0;
        end
    end

    // State, flags and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            sticky_q      <= '0;
            snap_q        <= '0;
            overrun_q     <= 1'b0;
            event_valid_q <= 1'b0;
            event_id_q    <= '0;
        end else begin
            state_q       <= state_d;
            sticky_q      <= sticky_d;
            snap_q        <= snap_d;
            overrun_q     <= overrun_d;
            event_valid_q <= event_valid_d;
            event_id_q    <= event_id_d;
        end
    end

    assign event_valid = event_valid_q;
    assign event_id    = event_id_q;
    assign overrun     = overrun_q;

`ifdef COLLISION_HIT_COUNT_EN
    logic [15:0] cnt_q [NUM_PAIRS];
    logic [15:0] cnt_d [NUM_PAIRS];
    logic [15:0] snap_cnt_q [NUM_PAIRS];
    logic [15:0] snap_cnt_d [NUM_PAIRS];
    logic [15:0] hit_count_q, hit_count_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic inc);
        if (inc && (c != 16'hFFFF)) begin
            sat_inc = c + 16'd1;
        end else begin
            sat_inc = c;
        end
    endfunction

    // A re-snapshotted pair takes its fresh count; a pair still pending from before keeps its old one.
    always_comb begin
        for (int p = 0; p < NUM_PAIRS; p++) begin
            cnt_d[p]      = sat_inc(cnt_q[p], hit_s[p]);
            snap_cnt_d[p] = snap_cnt_q[p];
            if (frame_s) begin
                cnt_d[p] = 16'd0;
                if (sticky_q[p] | hit_s[p]) begin
                    snap_cnt_d[p] = sat_inc(cnt_q[p], hit_s[p]);
                end else begin
                    snap_cnt_d[p] = snap_cnt_q[p];
                end
            end else begin
                cnt_d[p] = sat_inc(cnt_q[p], hit_s[p]);
            end
        end
        if (event_valid_d) begin
            hit_count_d = snap_cnt_d[event_id_d];
        end else begin
            hit_count_d = 16'd0;
        end
    end

    // Counter, snapshot-count and hit_count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PAIRS; p++) begin
                cnt_q[p]      <= 16'd0;
                snap_cnt_q[p] <= 16'd0;
            end
            hit_count_q <= 16'd0;
        end else begin
            for (int p = 0; p < NUM_PAIRS; p++) begin
                cnt_q[p]      <= cnt_d[p];
                snap_cnt_q[p] <= snap_cnt_d[p];
            end
            hit_count_q <= hit_count_d;
        end
    end

    assign hit_count = hit_count_q;
`endif

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed self-checking bench for collision_scheduler with the default pair map:
// pair0={4,5}, pair1={3,2}, pair2={0,2}, pair3={0,1}.
module tb_collision_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       pixel_valid = 1'b0;
    logic [5:0] drawReq = 6'd0;
    logic       startOfFrame = 1'b0;
    logic       event_ack = 1'b0;
    logic       event_valid;
    logic [1:0] event_id;
    logic       overrun;
`ifdef COLLISION_HIT_COUNT_EN
    logic [15:0] hit_count;
`endif

    int errors = 0;
    int checks = 0;

    collision_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .pixel_valid  (pixel_valid),
        .drawReq      (drawReq),
        .startOfFrame (startOfFrame),
        .event_valid  (event_valid),
        .event_id     (event_id),
        .event_ack    (event_ack),
`ifdef COLLISION_HIT_COUNT_EN
        .hit_count    (hit_count),
`endif
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pixels(input logic [5:0] req, input int n);
        pixel_valid = 1'b1;
        drawReq     = req;
        repeat (n) step();
        pixel_valid = 1'b0;
        drawReq     = 6'd0;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
    endtask

    task automatic ack();
        event_ack = 1'b1;
        step();
        event_ack = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        step();
        checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", event_valid); end
        checks++; if (event_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", event_id); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
`ifdef COLLISION_HIT_COUNT_EN
        checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL reset_hit_count got=%0d exp=0", hit_count); end
`endif
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_pair();
        pixels(6'b110000, 5);
        frame();
        checks++; if (event_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", event_valid); end
        checks++; if (event_id !== 2'd0) begin errors++; $display("FAIL single_id got=%0d exp=0", event_id); end
`ifdef COLLISION_HIT_COUNT_EN
        checks++; if (hit_count !== 16'd5) begin errors++; $display("FAIL single_hit_count got=%0d exp=5", hit_count); end
`endif
        ack();
        checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL single_after_ack got=%b exp=0", event_valid); end
    endtask

    task automatic test_multi();
        pixels(6'b001100, 1);
        pixels(6'b000011, 2);
        frame();
        checks++; if (event_valid !== 1'b1 || event_id !== 2'd1) begin errors++; $display("FAIL multi_first got=%b/%0d exp=1/1", event_valid, event_id); end
        ack();
        checks++; if (event_valid !== 1'b1 || event_id !== 2'd3) begin errors++; $display("FAIL multi_second got=%b/%0d exp=1/3", event_valid, event_id); end
`ifdef COLLISION_HIT_COUNT_EN
        checks++; if (hit_count !== 16'd2) begin errors++; $display("FAIL multi_hit_count got=%0d exp=2", hit_count); end
`endif
        ack();
        checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL multi_idle got=%b exp=0", event_valid); end
    endtask

    task automatic test_overrun();
        pixels(6'b110000, 1);
        pixels(6'b000101, 3);
        frame();
        checks++; if (event_id !== 2'd0 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_first got=id%0d/ovr%b exp=id0/ovr0", event_id, overrun); end
        pixels(6'b001100, 1);
        frame();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
        checks++; if (event_valid !== 1'b1 || event_id !== 2'd0) begin errors++; $display("FAIL ovr_id0 got=%b/%0d exp=1/0", event_valid, event_id); end
        ack();
        checks++; if (event_valid !== 1'b1 || event_id !== 2'd1) begin errors++; $display("FAIL ovr_id1 got=%b/%0d exp=1/1", event_valid, event_id); end
        ack();
        checks++; if (event_valid !== 1'b1 || event_id !== 2'd2) begin errors++; $display("FAIL ovr_id2 got=%b/%0d exp=1/2", event_valid, event_id); end
        ack();
        checks++; if (event_valid !== 1'b0 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_end got=v%b/ovr%b exp=v0/ovr1", event_valid, overrun); end
    endtask

    task automatic test_boundary();
        pulse_reset();
        pixel_valid  = 1'b1;
        drawReq      = 6'b000011;
        startOfFrame = 1'b1;
        step();
        pixel_valid  = 1'b0;
        drawReq      = 6'd0;
        startOfFrame = 1'b0;
        checks++; if (event_valid !== 1'b1 || event_id !== 2'd3) begin errors++; $display("FAIL bnd_same_cycle got=%b/%0d exp=1/3", event_valid, event_id); end
`ifdef COLLISION_HIT_COUNT_EN
        checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL bnd_hit_count got=%0d exp=1", hit_count); end
`endif
        ack();
        frame();
        checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL bnd_empty_frame got=%b exp=0", event_valid); end
        pixels(6'b110000, 1);
        frame();
        // Ack of the only pending event coincides with a new frame carrying a pair1 hit.
        pixel_valid  = 1'b1;
        drawReq      = 6'b001100;
        startOfFrame = 1'b1;
        event_ack    = 1'b1;
        step();
        pixel_valid  = 1'b0;
        drawReq      = 6'd0;
        startOfFrame = 1'b0;
        event_ack    = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bnd_ack_sof_overrun got=%b exp=0", overrun); end
        checks++; if (event_valid !== 1'b1 || event_id !== 2'd1) begin errors++; $display("FAIL bnd_ack_sof_id got=%b/%0d exp=1/1", event_valid, event_id); end
        ack();
        checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL bnd_final got=%b exp=0", event_valid); end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        pixels(6'b111111, 4);
        frame();
        checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL en_off_frame got=%b exp=0", event_valid); end
        enable = 1'b1;
        frame();
        checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL en_no_accum got=%b exp=0", event_valid); end
        pixels(6'b000011, 1);
        enable = 1'b0;
        frame();
        checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL en_sof_ignored got=%b exp=0", event_valid); end
        enable = 1'b1;
        frame();
        checks++; if (event_valid !== 1'b1 || event_id !== 2'd3) begin errors++; $display("FAIL en_sticky_held got=%b/%0d exp=1/3", event_valid, event_id); end
        enable = 1'b0;
        ack();
        checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL en_report_continues got=%b exp=0", event_valid); end
        enable = 1'b1;
`ifdef COLLISION_HIT_COUNT_EN
        pixels(6'b110000, 70000);
        frame();
        checks++; if (hit_count !== 16'hFFFF) begin errors++; $display("FAIL en_saturate got=%h exp=ffff", hit_count); end
        ack();
`endif
    endtask

    task automatic test_reset_mid_report();
        pixels(6'b110000, 1);
        frame();
        pixels(6'b000011, 1);
        frame();
        checks++; if (event_valid !== 1'b1 || overrun !== 1'b1) begin errors++; $display("FAIL rst_mid_setup got=v%b/ovr%b exp=v1/ovr1", event_valid, overrun); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (event_valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_async got=v%b/ovr%b exp=v0/ovr0", event_valid, overrun); end
        step();
        reset = 1'b0;
        step();
        frame();
        checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_after_sof got=%b exp=0", event_valid); end
        step();
        checks++; if (event_valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_later got=v%b/ovr%b exp=v0/ovr0", event_valid, overrun); end
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_multi();
        test_overrun();
        test_boundary();
        test_enable();
        test_reset_mid_report();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
